wb_demux: RTL

Registered 1-to-4 demultiplexer for the multicycle datapath: routes one 32-bit write-back word to one of four holding registers selected by a 2-bit code, the inverse of the 4:1 result mux. Each output channel holds one entry with a valid/ready handshake, so a producer (ALU, memory read, PC logic) can hand a word to a consumer (register file port, IR, MDR, PC) that is not yet ready. Sits between the datapath result sources and the state-holding registers, under control of the multicycle FSM.

---
 rtl/wb_demux.sv | 103 ++++++++++
 1 files changed

// File: rtl/wb_demux.sv
// wb_demux: registered 1-to-4 write-back demultiplexer. Each output channel
// is a one-entry valid/ready buffer, so a result source can hand a word to a
// consumer that is not ready yet. Flush empties every channel without
// touching the held data.

// One channel: a single holding register plus its valid bit.
module wb_demux_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  // Flush beats refill, refill beats drain. A refill in the same cycle as a
  // drain keeps the entry full, which gives back-to-back 1 word/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (flush) begin
      vld  <= 1'b0;
    end else if (wr) begin
      vld  <= 1'b1;
      data <= din;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

module wb_demux #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Flush,
  input  logic [1:0]       Select,
  input  logic [WIDTH-1:0] InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Data1,
  output logic [WIDTH-1:0] Data2,
  output logic [WIDTH-1:0] Data3,
  output logic [WIDTH-1:0] Data4,
  output logic             Valid1,
  output logic             Valid2,
  output logic             Valid3,
  output logic             Valid4,
  input  logic             Ready1,
  input  logic             Ready2,
  input  logic             Ready3,
  input  logic             Ready4,
  output logic             Busy
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            vld;
  logic [NUM_LANES-1:0]            rdy;
  logic [NUM_LANES-1:0]            wr;
  logic [NUM_LANES-1:0][WIDTH-1:0] data;
  logic                            acc;

  assign rdy = {Ready4, Ready3, Ready2, Ready1};

  // The addressed channel can take a word when it is empty or is being
  // drained this cycle; never depends on InValid.
  assign InReady = ~Flush & (~vld[Select] | rdy[Select]);
  assign acc     = InValid & InReady;
  assign Busy    = |vld;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_chan
    assign wr[i] = acc & (Select == 2'(i));

    wb_demux_chan #(.WIDTH(WIDTH)) u_chan (
      .clk   (CLK),
      .rst_n (RST_n),
      .flush (Flush),
      .wr    (wr[i]),
      .din   (InData),
      .rdy   (rdy[i]),
      .vld   (vld[i]),
      .data  (data[i])
    );
  end

  assign Data1  = data[0];
  assign Data2  = data[1];
  assign Data3  = data[2];
  assign Data4  = data[3];
  assign Valid1 = vld[0];
  assign Valid2 = vld[1];
  assign Valid3 = vld[2];
  assign Valid4 = vld[3];

endmodule
